// File: rtl/prbs_gen_chk_if.sv
// Handshake and data bundle between the PRBS generator/checker and the link datapath.
// The slave modport is the block's view; the master modport is the surrounding logic.
interface prbs_gen_chk_if #(
    parameter int unsigned NB_PAR    = 1,
    parameter int unsigned NB_ERRCNT = 32
);
    logic                 i_enable;
    logic                 i_valid;
    logic                 i_err_inj;
    logic [NB_PAR-1:0]    o_data;
    logic                 o_valid;
    logic [NB_PAR-1:0]    i_rx_data;
    logic                 i_rx_valid;
    logic                 i_clr_cnt;
    logic                 o_lock;
    logic                 o_err;
    logic [NB_ERRCNT-1:0] o_err_cnt;

    modport master (
        output i_enable, i_valid, i_err_inj, i_rx_data, i_rx_valid, i_clr_cnt,
        input  o_data, o_valid, o_lock, o_err, o_err_cnt
    );

    modport slave (
        input  i_enable, i_valid, i_err_inj, i_rx_data, i_rx_valid, i_clr_cnt,
        output o_data, o_valid, o_lock, o_err, o_err_cnt
    );
endinterface

// File: rtl/prbs_gen_chk.sv
// Parallel Fibonacci-LFSR PRBS generator and self-synchronising checker with a
// saturating bit-error counter; first bit of each word lands in the MSB.
module prbs_gen_chk #(
    parameter int unsigned      ORDER      = 9,
    parameter logic [ORDER-1:0] SEEDX      = ORDER'(9'b110101010),
    parameter int unsigned      NB_PAR     = 1,
    parameter int unsigned      NB_ERRCNT  = 32,
    parameter int unsigned      LOCK_WORDS = 16,
    parameter int unsigned      LOSS_WORDS = 4
) (
    input  logic          clock,
    input  logic          i_reset,
    prbs_gen_chk_if.slave bus
);
    localparam int unsigned TAP = (ORDER == 7)  ? 6  : (ORDER == 9)  ? 5  :
                                  (ORDER == 15) ? 14 : (ORDER == 23) ? 18 :
                                  (ORDER == 31) ? 28 : 1;
    localparam int unsigned FILL_WORDS = (ORDER + NB_PAR - 1) / NB_PAR;
    localparam int unsigned FILL_W     = $clog2(FILL_WORDS + 1);
    localparam int unsigned LOCK_W     = $clog2(LOCK_WORDS + 1);
    localparam int unsigned LOSS_W     = $clog2(LOSS_WORDS + 1);
    localparam int unsigned POP_W      = $clog2(NB_PAR + 1);
    localparam int unsigned SUM_W      = NB_ERRCNT + 1;

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    if (TAP == 1) begin : g_bad_order
        $error("prbs_gen_chk: ORDER must be one of 7, 9, 15, 23, 31");
    end
    if (SEEDX == '0) begin : g_bad_seed
        $error("prbs_gen_chk: SEEDX must be nonzero");
    end

    logic [ORDER-1:0]     gen_q, gen_d, gen_nxt;
    logic [NB_PAR-1:0]    gen_word;
    logic [NB_PAR-1:0]    data_q, data_d;
    logic                 valid_q, valid_d;
    logic [ORDER-1:0]     chk_q, chk_d, chk_nxt;
    logic [NB_PAR-1:0]    mism;
    logic [POP_W-1:0]     pop;
    logic [1:0]           state_q, state_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [LOCK_W-1:0]    clean_q, clean_d;
    logic [LOSS_W-1:0]    loss_q, loss_d;
    logic                 lock_q, lock_d;
    logic                 err_q, err_d;
    logic [NB_ERRCNT-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0]     sum;
    logic                 word_err;

    // Generator: NB_PAR bit steps from the current LFSR state.
    always_comb begin
        logic fb;
        gen_nxt  = gen_q;
        gen_word = '0;
        for (int i = 0; i < NB_PAR; i++) begin
            fb                     = gen_nxt[ORDER-1] ^ gen_nxt[TAP-1];
            gen_word[NB_PAR-1-i]   = fb;
            gen_nxt                = {gen_nxt[ORDER-2:0], fb};
        end
    end

    // Checker: predict each received bit; reload from rx until locked, free-run once locked.
    always_comb begin
        logic pred;
        logic rxb;
        chk_nxt = chk_q;
        mism    = '0;
        pop     = '0;
        for (int i = 0; i < NB_PAR; i++) begin
            pred               = chk_nxt[ORDER-1] ^ chk_nxt[TAP-1];
            rxb                = bus.i_rx_data[NB_PAR-1-i];
            mism[NB_PAR-1-i]   = pred ^ rxb;
            chk_nxt            = {chk_nxt[ORDER-2:0], (state_q == LOCKED) ? pred : rxb};
        end
        for (int i = 0; i < NB_PAR; i++) begin
            pop = pop + POP_W'(mism[i]);
        end
    end

    assign sum = {1'b0, cnt_q} + SUM_W'(pop);

    always_comb begin
        gen_d    = gen_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        chk_d    = chk_q;
        state_d  = state_q;
        fill_d   = fill_q;
        clean_d  = clean_q;
        loss_d   = loss_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        word_err = |mism;
        if (bus.i_enable) begin
            if (bus.i_valid) begin
                gen_d   = gen_nxt;
                data_d  = gen_word ^ NB_PAR'(bus.i_err_inj);
                valid_d = 1'b1;
            end
            err_d = 1'b0;
            if (bus.i_rx_valid) begin
                chk_d = chk_nxt;
                case (state_q)
                    SEARCH: begin
                        if (fill_q == FILL_W'(FILL_WORDS - 1)) begin
                            state_d = VERIFY;
                            fill_d  = '0;
                            clean_d = '0;
                        end else begin
                            fill_d = fill_q + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (word_err) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                        end else if (clean_q == LOCK_W'(LOCK_WORDS - 1)) begin
                            state_d = LOCKED;
                            loss_d  = '0;
                        end else begin
                            clean_d = clean_q + LOCK_W'(1);
                        end
                    end
                    LOCKED: begin
                        err_d = word_err;
                        cnt_d = sum[NB_ERRCNT] ? '1 : sum[NB_ERRCNT-1:0];
                        if (!word_err) begin
                            loss_d = '0;
                        end else if (loss_q == LOSS_W'(LOSS_WORDS - 1)) begin
                            state_d = SEARCH;
                            fill_d  = '0;
                        end else begin
                            loss_d = loss_q + LOSS_W'(1);
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
            if (bus.i_clr_cnt) begin
                cnt_d = '0;
            end
        end
        lock_d = (state_d == LOCKED);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            gen_q   <= SEEDX;
            data_q  <= '0;
            valid_q <= 1'b0;
            chk_q   <= '0;
            state_q <= SEARCH;
            fill_q  <= '0;
            clean_q <= '0;
            loss_q  <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            gen_q   <= gen_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            chk_q   <= chk_d;
            state_q <= state_d;
            fill_q  <= fill_d;
            clean_q <= clean_d;
            loss_q  <= loss_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_lock    = lock_q;
    assign bus.o_err     = err_q;
    assign bus.o_err_cnt = cnt_q;
endmodule
